titan_lsu: RTL

Load/store unit between the memory stage and the data-side Wishbone bus. It takes the memory-stage access flags, address and store data. It runs one Wishbone classic cycle per access, handles byte-lane steering and load sign/zero extension, and detects misaligned accesses and bus errors/timeouts. It returns data, cycle and ack handshakes that the memory stage turns into its stall request and load-result mux.

---
 rtl/titan_lsu_pkg.sv | 38 +++
 rtl/titan_lsu_if.sv | 29 ++
 rtl/titan_lsu_align.sv | 51 +++++
 rtl/titan_lsu.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/titan_lsu_pkg.sv
// titan_lsu_pkg
//   Shared definitions for the data-side load/store unit: FSM state
//   encoding, access-size encoding, Wishbone byte-select patterns and the
//   default bus timeout.
package titan_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [3:0] SEL_BYTE0   = 4'b0001;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Word wins over halfword, halfword over byte; with no size flag the
  // access is treated as a byte.
  function automatic lsu_size_e decode_size(input logic i_byte,
                                            input logic i_hw,
                                            input logic i_word);
    if (i_word)      return SZ_WORD;
    else if (i_hw)   return SZ_HALF;
    else if (i_byte) return SZ_BYTE;
    else             return SZ_BYTE;
  endfunction

endpackage

// File: rtl/titan_lsu_if.sv
// titan_lsu_if
//   Data-side Wishbone classic bus between the LSU (master) and the data
//   memory/interconnect (slave).
//   dwbm_addr_o  word-aligned byte address      dwbm_dat_o  store data
//   dwbm_sel_o   byte lane selects              dwbm_we_o   write enable
//   dwbm_cyc_o   bus cycle                      dwbm_stb_o  strobe
//   dwbm_dat_i   read data                      dwbm_ack_i  ack
//   dwbm_err_i   bus error
interface titan_lsu_if;
  logic [31:0] dwbm_addr_o;
  logic [31:0] dwbm_dat_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o;
  logic        dwbm_cyc_o;
  logic        dwbm_stb_o;
  logic [31:0] dwbm_dat_i;
  logic        dwbm_ack_i;
  logic        dwbm_err_i;

  modport master (
    output dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_we_o, dwbm_cyc_o, dwbm_stb_o,
    input  dwbm_dat_i, dwbm_ack_i, dwbm_err_i
  );

  modport slave (
    input  dwbm_addr_o, dwbm_dat_o, dwbm_sel_o, dwbm_we_o, dwbm_cyc_o, dwbm_stb_o,
    output dwbm_dat_i, dwbm_ack_i, dwbm_err_i
  );
endinterface

// File: rtl/titan_lsu_align.sv
// titan_lsu_align
//   Purely combinational byte-lane logic for the LSU.
//   i_addr_lo    address bits [1:0]          i_size      access size
//   i_unsigned   zero-extend loads           i_wdata     right-aligned store data
//   i_rdata      raw bus read data
//   o_sel        byte selects                o_wdat      lane-replicated store data
//   o_rdata      extracted, extended load    o_misaligned size/address mismatch
module titan_lsu_align
  import titan_lsu_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdat,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_sel        = SEL_WORD;
    o_wdat       = i_wdata;
    o_rdata      = i_rdata;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_sel   = SEL_BYTE0 << i_addr_lo;
        o_wdat  = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_sel        = i_addr_lo[1] ? SEL_HALF_HI : SEL_HALF_LO;
        o_wdat       = {2{i_wdata[15:0]}};
        o_rdata      = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_misaligned = |i_addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/titan_lsu.sv
// titan_lsu
//   Load/store unit between the memory stage and the data-side Wishbone
//   bus. One Wishbone classic cycle per aligned access; misaligned accesses
//   complete without a bus cycle and raise a flag.
//   clk_i, rst_i            clock, asynchronous active-high reset
//   lsu_stall_i             hold a completed result presented
//   lsu_flush_i             kill the access in the memory stage
//   lsu_addr_i/lsu_wdata_i  byte address, right-aligned store data
//   lsu_m*_i                read/write/size/unsigned access flags
//   lsu_data_o              formatted load data
//   lsu_cyc_o/lsu_ack_o     access in progress / access complete
//   lsu_*_misaligned_o      misaligned load/store
//   lsu_bus_fault_o         bus error or timeout
//   dwbm                    Wishbone master port
module titan_lsu
  import titan_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_stall_i,
  input  logic        lsu_flush_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_mread_i,
  input  logic        lsu_mwrite_i,
  input  logic        lsu_mbyte_i,
  input  logic        lsu_mhw_i,
  input  logic        lsu_mword_i,
  input  logic        lsu_munsigned_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_cyc_o,
  output logic        lsu_ack_o,
  output logic        lsu_load_misaligned_o,
  output logic        lsu_store_misaligned_o,
  output logic        lsu_bus_fault_o,
  titan_lsu_if.master dwbm
);

  // Timeout counter is 8 bits wide.
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  lsu_state_e  r_state;
  logic [1:0]  r_addr_lo;
  lsu_size_e   r_size;
  logic        r_unsigned;
  logic [7:0]  r_count;
  logic [31:0] r_data;
  logic        r_lmis;
  logic        r_smis;
  logic        r_fault;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_dat;
  logic [3:0]  r_bus_sel;
  logic        r_bus_we;
  logic        r_bus_cyc;

  logic        w_req;
  logic        w_is_load;
  lsu_size_e   w_size;
  logic [1:0]  w_al_addr;
  lsu_size_e   w_al_size;
  logic        w_al_uns;
  logic [3:0]  w_sel;
  logic [31:0] w_wdat;
  logic [31:0] w_rdata;
  logic        w_mis;
  logic        w_tmo;
  logic [7:0]  w_count_nxt;

  assign w_req     = (lsu_mread_i | lsu_mwrite_i) & ~lsu_flush_i;
  assign w_is_load = lsu_mread_i;
  assign w_size    = decode_size(lsu_mbyte_i, lsu_mhw_i, lsu_mword_i);

  // The aligner sees the live request while idle (lane steering, misalign
  // check) and the latched access while the bus cycle runs (load format).
  assign w_al_addr = (r_state == ST_IDLE) ? lsu_addr_i[1:0] : r_addr_lo;
  assign w_al_size = (r_state == ST_IDLE) ? w_size : r_size;
  assign w_al_uns  = (r_state == ST_IDLE) ? lsu_munsigned_i : r_unsigned;

  titan_lsu_align u_align (
    .i_addr_lo    (w_al_addr),
    .i_size       (w_al_size),
    .i_unsigned   (w_al_uns),
    .i_wdata      (lsu_wdata_i),
    .i_rdata      (dwbm.dwbm_dat_i),
    .o_sel        (w_sel),
    .o_wdat       (w_wdat),
    .o_rdata      (w_rdata),
    .o_misaligned (w_mis)
  );

  assign w_tmo       = (r_count == TMO_LIMIT);
  assign w_count_nxt = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_addr_lo  <= '0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_count    <= '0;
      r_data     <= '0;
      r_lmis     <= 1'b0;
      r_smis     <= 1'b0;
      r_fault    <= 1'b0;
      r_bus_addr <= '0;
      r_bus_dat  <= '0;
      r_bus_sel  <= '0;
      r_bus_we   <= 1'b0;
      r_bus_cyc  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_mis) begin
              r_lmis  <= w_is_load;
              r_smis  <= ~w_is_load;
              r_data  <= '0;
              r_state <= ST_DONE;
            end else begin
              r_bus_addr <= {lsu_addr_i[31:2], 2'b00};
              r_bus_dat  <= w_wdat;
              r_bus_sel  <= w_sel;
              r_bus_we   <= ~w_is_load;
              r_bus_cyc  <= 1'b1;
              r_addr_lo  <= lsu_addr_i[1:0];
              r_size     <= w_size;
              r_unsigned <= lsu_munsigned_i;
              r_count    <= '0;
              r_state    <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // A flush in the closing cycle still lets the bus cycle finish,
          // but the result is discarded.
          if (dwbm.dwbm_ack_i) begin
            r_bus_cyc <= 1'b0;
            if (lsu_flush_i) begin
              r_state <= ST_IDLE;
            end else begin
              r_data  <= r_bus_we ? '0 : w_rdata;
              r_state <= ST_DONE;
            end
          end else if (dwbm.dwbm_err_i || w_tmo) begin
            r_bus_cyc <= 1'b0;
            if (lsu_flush_i) begin
              r_state <= ST_IDLE;
            end else begin
              r_fault <= 1'b1;
              r_data  <= '0;
              r_state <= ST_DONE;
            end
          end else begin
            r_count <= w_count_nxt;
            if (lsu_flush_i) r_state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (dwbm.dwbm_ack_i || dwbm.dwbm_err_i || w_tmo) begin
            r_bus_cyc <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_count <= w_count_nxt;
          end
        end
        ST_DONE: begin
          if (!lsu_stall_i || lsu_flush_i) begin
            r_lmis  <= 1'b0;
            r_smis  <= 1'b0;
            r_fault <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign lsu_cyc_o              = (r_state != ST_IDLE) | w_req;
  assign lsu_ack_o              = (r_state == ST_DONE);
  assign lsu_data_o             = r_data;
  assign lsu_load_misaligned_o  = r_lmis;
  assign lsu_store_misaligned_o = r_smis;
  assign lsu_bus_fault_o        = r_fault;

  assign dwbm.dwbm_addr_o = r_bus_addr;
  assign dwbm.dwbm_dat_o  = r_bus_dat;
  assign dwbm.dwbm_sel_o  = r_bus_sel;
  assign dwbm.dwbm_we_o   = r_bus_we;
  assign dwbm.dwbm_cyc_o  = r_bus_cyc;
  assign dwbm.dwbm_stb_o  = r_bus_cyc;

endmodule
